apb_debug_fanout_bridge: RTL and testbench

- Registered APB4 bridge: one upstream APB completer port (driven by the APB VIP master or the debug requester) fanned out to NUM_SLV downstream APB requester ports.
- Performs address decode, PPROT secure-bit override, PSTRB normalisation, per-transfer timeout and error reporting.
- Replaces fixed single-slave assign-through wiring in debug/ATU register paths, where multiple debug register blocks share one APB master.

---
 rtl/apb_debug_fanout_bridge.sv | 184 ++++++++++++++++++
 tb/tb_apb_debug_fanout_bridge.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_debug_fanout_bridge.sv
// Registered APB4 bridge: one upstream completer port fanned out to NUM_SLV downstream
// requester ports, with address decode, PPROT secure override, PSTRB normalisation and timeout.
module apb_debug_fanout_bridge #(
    parameter int                          ADDR_W       = 32,
    parameter int                          DATA_W       = 32,
    parameter int                          NUM_SLV      = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE     = {NUM_SLV{32'h0000_0000}},
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK     = {NUM_SLV{32'hFFFF_F000}},
    parameter bit                          FORCE_SECURE = 1'b1,
    parameter bit                          HAS_STRB     = 1'b1,
    parameter int                          TIMEOUT_CYC  = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_W-1:0]         s_paddr,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [DATA_W-1:0]         s_pwdata,
    input  logic [2:0]                s_pprot,
    input  logic [DATA_W/8-1:0]       s_pstrb,
    output logic                      s_pready,
    output logic [DATA_W-1:0]         s_prdata,
    output logic                      s_pslverr,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [NUM_SLV-1:0]        m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [DATA_W-1:0]         m_pwdata,
    output logic [2:0]                m_pprot,
    output logic [DATA_W/8-1:0]       m_pstrb,
    input  logic [NUM_SLV-1:0]        m_pready,
    input  logic [NUM_SLV*DATA_W-1:0] m_prdata,
    input  logic [NUM_SLV-1:0]        m_pslverr,
    output logic [7:0]                err_cnt
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SLOT_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W  = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [NUM_SLV-1:0] ONE_SLV  = NUM_SLV'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                s_pready_q;
    logic                s_pslverr_q;
    logic [DATA_W-1:0]   s_prdata_q;
    logic [ADDR_W-1:0]   m_paddr_q;
    logic [NUM_SLV-1:0]  m_psel_q;
    logic                m_penable_q;
    logic                m_pwrite_q;
    logic [DATA_W-1:0]   m_pwdata_q;
    logic [2:0]          m_pprot_q;
    logic [STRB_W-1:0]   m_pstrb_q;
    logic [7:0]          err_cnt_q;

    logic                hit_d;
    logic [SLOT_W-1:0]   slot_d;
    logic                sel_ready_s;
    logic                sel_err_s;
    logic [DATA_W-1:0]   sel_rdata_s;

    // Address decode; scanning downwards lets the lowest matching window win.
    always_comb begin
        hit_d  = 1'b0;
        slot_d = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            hit_d  = hit_d | ((s_paddr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                              (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]));
            slot_d = ((s_paddr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                      (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]))
                     ? SLOT_W'(i) : slot_d;
        end
    end

    // Response signals of the currently selected downstream slot.
    always_comb begin
        sel_ready_s = m_pready[slot_q];
        sel_err_s   = m_pslverr[slot_q];
        sel_rdata_s = m_prdata[slot_q*DATA_W +: DATA_W];
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            cnt_q       <= '0;
            s_pready_q  <= 1'b0;
            s_pslverr_q <= 1'b0;
            s_prdata_q  <= '0;
            m_paddr_q   <= '0;
            m_psel_q    <= '0;
            m_penable_q <= 1'b0;
            m_pwrite_q  <= 1'b0;
            m_pwdata_q  <= '0;
            m_pprot_q   <= 3'b000;
            m_pstrb_q   <= '0;
            err_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_psel && !s_penable) begin
                        m_paddr_q  <= s_paddr;
                        m_pwrite_q <= s_pwrite;
                        m_pwdata_q <= s_pwdata;
                        m_pprot_q  <= {s_pprot[2], (FORCE_SECURE ? 1'b0 : s_pprot[1]), s_pprot[0]};
                        m_pstrb_q  <= !s_pwrite ? '0 : (HAS_STRB ? s_pstrb : '1);
                        slot_q     <= slot_d;
                        cnt_q      <= '0;
                        if (hit_d) begin
                            m_psel_q <= ONE_SLV << slot_d;
                            state_q  <= ST_SETUP;
                        end else begin
                            s_pready_q  <= 1'b1;
                            s_pslverr_q <= 1'b1;
                            s_prdata_q  <= '0;
                            err_cnt_q   <= (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    m_penable_q <= 1'b1;
                    state_q     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_ready_s) begin
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        s_pready_q  <= 1'b1;
                        s_pslverr_q <= sel_err_s;
                        s_prdata_q  <= (m_pwrite_q || sel_err_s) ? '0 : sel_rdata_s;
                        cnt_q       <= '0;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abort: the slave never answered, so drop the select and report an error.
                        m_psel_q    <= '0;
                        m_penable_q <= 1'b0;
                        s_pready_q  <= 1'b1;
                        s_pslverr_q <= 1'b1;
                        s_prdata_q  <= '0;
                        cnt_q       <= '0;
                        err_cnt_q   <= (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    s_pready_q  <= 1'b0;
                    s_pslverr_q <= 1'b0;
                    s_prdata_q  <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_pready  = s_pready_q;
    assign s_pslverr = s_pslverr_q;
    assign s_prdata  = s_prdata_q;
    assign m_paddr   = m_paddr_q;
    assign m_psel    = m_psel_q;
    assign m_penable = m_penable_q;
    assign m_pwrite  = m_pwrite_q;
    assign m_pwdata  = m_pwdata_q;
    assign m_pprot   = m_pprot_q;
    assign m_pstrb   = m_pstrb_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_apb_debug_fanout_bridge.sv
// Randomised bench for apb_debug_fanout_bridge: a transaction-level timeline model predicts
// every cycle of two bridge variants (secure/strobed and pass-through/all-ones).
module tb_apb_debug_fanout_bridge;

    localparam int TO = 8;
    localparam logic [127:0] P_BASE = {32'h0000_2000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [127:0] P_MASK = {32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  s_paddr = 32'h0, s_pwdata = 32'h0;
    logic         s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
    logic [2:0]   s_pprot = 3'b000;
    logic [3:0]   s_pstrb = 4'h0;
    logic [3:0]   m_pready = 4'h0, m_pslverr = 4'h0;
    logic [127:0] m_prdata = 128'h0;

    logic a_sready, a_serr, a_pen, a_pwrite, b_sready, b_serr, b_pen, b_pwrite;
    logic [31:0] a_srdata, a_paddr, a_pwdata, b_srdata, b_paddr, b_pwdata;
    logic [3:0]  a_psel, a_pstrb, b_psel, b_pstrb;
    logic [2:0]  a_pprot, b_pprot;
    logic [7:0]  a_errcnt, b_errcnt;

    // Expected values for the current cycle, set by the stimulus timeline.
    logic        exp_sready = 1'b0, exp_serr = 1'b0, exp_pen = 1'b0, exp_pwrite = 1'b0;
    logic        exp_chk_m = 1'b0, exp_zero = 1'b1;
    logic [31:0] exp_srdata = 32'h0, exp_paddr = 32'h0, exp_pwdata = 32'h0;
    logic [3:0]  exp_psel = 4'h0, exp_strb_a = 4'h0, exp_strb_b = 4'h0;
    logic [2:0]  exp_prot_a = 3'b000, exp_prot_b = 3'b000;
    logic [7:0]  exp_errcnt = 8'd0;

    int checks = 0, errors = 0, cyc = 0;
    int t0 = 0, resp_at = -1, ready_at = -1, pen_cnt = 0;
    logic [31:0] resp_data = 32'h0;
    logic        resp_err = 1'b0;
    logic [3:0]  seen_psel = 4'h0, seen_strb_a = 4'h0, seen_strb_b = 4'h0;
    logic [2:0]  seen_prot_a = 3'b000, seen_prot_b = 3'b000;

    apb_debug_fanout_bridge #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_BASE(P_BASE), .SLV_MASK(P_MASK),
        .FORCE_SECURE(1'b1), .HAS_STRB(1'b1), .TIMEOUT_CYC(TO)) dut_a (
        .clk(clk), .reset(reset), .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pprot(s_pprot), .s_pstrb(s_pstrb),
        .s_pready(a_sready), .s_prdata(a_srdata), .s_pslverr(a_serr), .m_paddr(a_paddr),
        .m_psel(a_psel), .m_penable(a_pen), .m_pwrite(a_pwrite), .m_pwdata(a_pwdata),
        .m_pprot(a_pprot), .m_pstrb(a_pstrb), .m_pready(m_pready), .m_prdata(m_prdata),
        .m_pslverr(m_pslverr), .err_cnt(a_errcnt));

    apb_debug_fanout_bridge #(.ADDR_W(32), .DATA_W(32), .NUM_SLV(4), .SLV_BASE(P_BASE), .SLV_MASK(P_MASK),
        .FORCE_SECURE(1'b0), .HAS_STRB(1'b0), .TIMEOUT_CYC(TO)) dut_b (
        .clk(clk), .reset(reset), .s_paddr(s_paddr), .s_psel(s_psel), .s_penable(s_penable),
        .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pprot(s_pprot), .s_pstrb(s_pstrb),
        .s_pready(b_sready), .s_prdata(b_srdata), .s_pslverr(b_serr), .m_paddr(b_paddr),
        .m_psel(b_psel), .m_penable(b_pen), .m_pwrite(b_pwrite), .m_pwdata(b_pwdata),
        .m_pprot(b_pprot), .m_pstrb(b_pstrb), .m_pready(m_pready), .m_prdata(m_prdata),
        .m_pslverr(m_pslverr), .err_cnt(b_errcnt));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model, plus observation of what the bridge presented.
    always @(negedge clk) begin
        chk("s_resp_a", {a_sready, a_serr, a_srdata}, {exp_sready, exp_serr, exp_srdata});
        chk("s_resp_b", {b_sready, b_serr, b_srdata}, {exp_sready, exp_serr, exp_srdata});
        chk("m_ctl_a", {a_psel, a_pen}, {exp_psel, exp_pen});
        chk("m_ctl_b", {b_psel, b_pen}, {exp_psel, exp_pen});
        chk("err_cnt_a", a_errcnt, exp_errcnt);
        chk("err_cnt_b", b_errcnt, exp_errcnt);
        if (exp_chk_m) begin
            chk("m_attr_a", {a_paddr, a_pwrite, a_pwdata, a_pprot, a_pstrb},
                {exp_paddr, exp_pwrite, exp_pwdata, exp_prot_a, exp_strb_a});
            chk("m_attr_b", {b_paddr, b_pwrite, b_pwdata, b_pprot, b_pstrb},
                {exp_paddr, exp_pwrite, exp_pwdata, exp_prot_b, exp_strb_b});
        end
        if (exp_zero) begin
            chk("rst_zero_a", {a_paddr, a_pwdata, a_pwrite, a_pprot, a_pstrb}, 80'd0);
            chk("rst_zero_b", {b_paddr, b_pwdata, b_pwrite, b_pprot, b_pstrb}, 80'd0);
        end
        if (a_sready) begin
            resp_at   = cyc;
            resp_data = a_srdata;
            resp_err  = a_serr;
        end
        if (a_psel != 4'h0) begin
            seen_psel   = seen_psel | a_psel;
            seen_strb_a = seen_strb_a | a_pstrb;
            seen_strb_b = seen_strb_b | b_pstrb;
            seen_prot_a = a_pprot;
            seen_prot_b = b_pprot;
        end
        if (a_pen) pen_cnt++;
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & P_MASK[i*32 +: 32]) == (P_BASE[i*32 +: 32] & P_MASK[i*32 +: 32])) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_slaves();
        m_pready  = 4'($urandom);
        m_pslverr = 4'($urandom);
        m_prdata  = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic set_idle_exp();
        exp_psel = 4'h0; exp_pen = 1'b0; exp_sready = 1'b0; exp_serr = 1'b0;
        exp_srdata = 32'h0; exp_chk_m = 1'b0; exp_zero = 1'b0;
    endtask

    task automatic bump_err();
        if (exp_errcnt != 8'd255) exp_errcnt = exp_errcnt + 8'd1;
    endtask

    task automatic idle_cycle();
        s_psel = 1'b0; s_penable = 1'b0; s_paddr = $urandom;
        set_idle_exp();
        rand_slaves();
        step();
    endtask

    // One upstream transfer; w = ACCESS cycle index at which the slave answers (>= TO: never).
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                        input logic [2:0] prot, input logic [3:0] strb, input int w,
                        input logic serr, input logic [31:0] rd, input int rst_at, input logic drop);
        int   slot;
        int   j;
        logic done;
        slot = decode(addr);
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwrite = wr;
        s_pwdata = wd; s_pprot = prot; s_pstrb = strb;
        set_idle_exp();
        rand_slaves();
        t0 = cyc; resp_at = -1; ready_at = -1; pen_cnt = 0;
        seen_psel = 4'h0; seen_strb_a = 4'h0; seen_strb_b = 4'h0;
        step();
        s_penable = 1'b1;
        rand_slaves();
        if (slot < 0) begin
            bump_err();
            exp_sready = 1'b1; exp_serr = 1'b1; exp_srdata = 32'h0;
            step();
            return;
        end
        exp_chk_m = 1'b1; exp_paddr = addr; exp_pwrite = wr; exp_pwdata = wd;
        exp_prot_a = {prot[2], 1'b0, prot[0]};
        exp_prot_b = prot;
        exp_strb_a = wr ? strb : 4'h0;
        exp_strb_b = wr ? 4'hF : 4'h0;
        exp_psel = 4'b0001 << slot;
        step();
        j = 0; done = 1'b0;
        while (!done) begin
            exp_pen = 1'b1;
            if (drop) s_psel = 1'b0;
            rand_slaves();
            m_pready[slot] = (j == w);
            if (j == w) begin
                m_pslverr[slot] = serr;
                m_prdata[slot*32 +: 32] = rd;
                ready_at = cyc;
            end
            if (j == rst_at) begin
                reset = 1'b1;
                exp_errcnt = 8'd0;
                set_idle_exp();
                exp_zero = 1'b1;
                step();
                reset = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
                return;
            end
            done = (j == w) || (j == TO - 1);
            step();
            j++;
        end
        exp_psel = 4'h0; exp_pen = 1'b0; exp_sready = 1'b1;
        if (w < TO) begin
            exp_serr = serr;
            exp_srdata = (wr || serr) ? 32'h0 : rd;
        end else begin
            exp_serr = 1'b1;
            exp_srdata = 32'h0;
            bump_err();
        end
        rand_slaves();
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] addr;
        int          r;
        #1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        idle_cycle();

        // Zero-wait write to slot 2 (window overlaps slot 3; slot 2 must win).
        xfer(32'h0000_2010, 1'b1, 32'hA5A5_0001, 3'b010, 4'hF, 0, 1'b0, 32'h0, -1, 1'b0);
        chk("wr_latency", resp_at - t0, 80'd3);
        chk("wr_psel", seen_psel, 80'h4);
        chk("wr_pstrb", seen_strb_a, 80'hF);
        chk("wr_pslverr", resp_err, 80'd0);
        idle_cycle();

        // Read from slot 1 with a 5-cycle delayed ready.
        xfer(32'h0000_1004, 1'b0, 32'hDEAD_BEEF, 3'b000, 4'hF, 5, 1'b0, 32'h1234_5678, -1, 1'b0);
        chk("rd_data", resp_data, 80'h1234_5678);
        chk("rd_resp_delay", resp_at - ready_at, 80'd1);
        chk("rd_pstrb_a", seen_strb_a, 80'h0);
        chk("rd_pstrb_b", seen_strb_b, 80'h0);
        chk("rd_psel", seen_psel, 80'h2);

        // Decode miss.
        xfer(32'h0002_0000, 1'b0, 32'h0, 3'b000, 4'h0, 0, 1'b0, 32'h0, -1, 1'b0);
        chk("miss_latency", resp_at - t0, 80'd1);
        chk("miss_pslverr", resp_err, 80'd1);
        chk("miss_psel", seen_psel, 80'h0);
        chk("miss_err_cnt", a_errcnt, 80'd1);

        // Slot 0 never ready: timeout after TO access cycles.
        xfer(32'h0000_0040, 1'b0, 32'h0, 3'b000, 4'h0, 100, 1'b0, 32'hFFFF_FFFF, -1, 1'b0);
        chk("to_access_cycles", pen_cnt, 80'd8);
        chk("to_pslverr", resp_err, 80'd1);
        chk("to_prdata", resp_data, 80'h0);
        chk("to_err_cnt", a_errcnt, 80'd2);
        idle_cycle();

        // Protection override and strobe normalisation.
        xfer(32'h0000_1008, 1'b1, 32'h0BAD_F00D, 3'b111, 4'h3, 1, 1'b0, 32'h0, -1, 1'b1);
        chk("prot_secure", seen_prot_a, 80'h5);
        chk("prot_pass", seen_prot_b, 80'h7);
        chk("strb_has", seen_strb_a, 80'h3);
        chk("strb_none", seen_strb_b, 80'hF);

        // Slave error on a read returns zero data.
        xfer(32'h0000_0100, 1'b0, 32'h0, 3'b000, 4'h0, 2, 1'b1, 32'hCAFE_0001, -1, 1'b0);
        chk("slverr_flag", resp_err, 80'd1);
        chk("slverr_data", resp_data, 80'h0);

        // Reset in ACCESS, then a normal transfer.
        xfer(32'h0000_2000, 1'b1, 32'h1111_2222, 3'b000, 4'hF, 100, 1'b0, 32'h0, 2, 1'b0);
        idle_cycle();
        xfer(32'h0000_5000, 1'b0, 32'h0, 3'b001, 4'h0, 1, 1'b0, 32'h7777_8888, -1, 1'b0);
        chk("post_rst_latency", resp_at - t0, 80'd4);
        chk("post_rst_data", resp_data, 80'h7777_8888);
        chk("post_rst_psel", seen_psel, 80'h8);
        idle_cycle();

        // Randomised traffic.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    addr = 32'h0000_0000 | 32'($urandom_range(0, 4095));
                2, 3:    addr = 32'h0000_1000 | 32'($urandom_range(0, 4095));
                4, 5:    addr = 32'h0000_2000 | 32'($urandom_range(0, 4095));
                6, 7:    addr = 32'h0000_3000 + 32'($urandom_range(0, 32'h0000_CFFF));
                default: addr = 32'h0001_0000 + 32'($urandom);
            endcase
            if (addr < 32'h0001_0000 && r >= 8) addr = 32'h0001_0000;
            xfer(addr, 1'($urandom), $urandom, 3'($urandom), 4'($urandom),
                 $urandom_range(0, 9), ($urandom_range(0, 3) == 0), $urandom, -1,
                 ($urandom_range(0, 7) == 0));
            for (int g = 0; g < $urandom_range(0, 2); g++) idle_cycle();
        end

        // Back-to-back decode misses saturate the error counter.
        for (int n = 0; n < 300; n++) begin
            xfer(32'h0002_0000 + 32'(n), 1'($urandom), $urandom, 3'($urandom), 4'($urandom),
                 0, 1'b0, 32'h0, -1, 1'b0);
        end
        idle_cycle();
        chk("err_cnt_sat_a", a_errcnt, 80'd255);
        chk("err_cnt_sat_b", b_errcnt, 80'd255);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
